// File: rtl/attopu_seq.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the attopu 16-bit datapath.
// Optional retired-instruction counter enabled by defining ATTOPU_SEQ_PERF_EN.
module attopu_seq #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] PC,
  output logic [1:0]  rf_raddr1,
  output logic [1:0]  rf_raddr2,
  output logic        alu_en,
  output logic        rf_we,
  output logic [1:0]  rf_waddr,
  input  logic        halt_req,
  output logic        halted,
  output logic        err
`ifdef ATTOPU_SEQ_PERF_EN
  ,output logic [15:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT_EXT, S_HALT_STOP, S_ERR
  } state_e;

  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] pc_q, instr_q;
  logic [7:0]  wcnt_q;
  logic        req_q, alu_en_q, rf_we_q, halted_q, err_q;
  logic [1:0]  raddr1_q, raddr2_q, waddr_q;
  logic [3:0]  op;
`ifdef ATTOPU_SEQ_PERF_EN
  logic [15:0] retired_q;
`endif

  assign op = instr_q[15:12];

  // Strobes default low each cycle; only the state being entered raises them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      wcnt_q   <= '0;
      req_q    <= 1'b0;
      alu_en_q <= 1'b0;
      rf_we_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      waddr_q  <= '0;
`ifdef ATTOPU_SEQ_PERF_EN
      retired_q <= '0;
`endif
    end else begin
      req_q    <= 1'b0;
      alu_en_q <= 1'b0;
      rf_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q  <= imem_rdata;
            raddr1_q <= imem_rdata[9:8];
            raddr2_q <= imem_rdata[7:6];
            waddr_q  <= imem_rdata[11:10];
            state_q  <= S_DECODE;
          end else if (wcnt_q == WAIT_LAST) begin
            wcnt_q   <= wcnt_q + 8'd1;
            state_q  <= S_ERR;
            err_q    <= 1'b1;
            halted_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
            req_q  <= 1'b1;
          end
        end
        S_DECODE: begin
          wcnt_q   <= '0;
          alu_en_q <= 1'b1;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          if (op == OP_HALT) begin
            state_q  <= S_HALT_STOP;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_WB;
            rf_we_q <= (op != OP_JMP);
          end
        end
        S_WB: begin
          pc_q <= (op == OP_JMP) ? {8'h00, instr_q[7:0]} : pc_q + 16'd1;
`ifdef ATTOPU_SEQ_PERF_EN
          retired_q <= retired_q + 16'd1;
`endif
          if (halt_req) begin
            state_q  <= S_HALT_EXT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_HALT_EXT: begin
          if (!halt_req) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
            req_q    <= 1'b1;
          end
        end
        // HALT_STOP and ERR are terminal until reset.
        default: state_q <= state_q;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign instruction = instr_q;
  assign rf_raddr1   = raddr1_q;
  assign rf_raddr2   = raddr2_q;
  assign rf_waddr    = waddr_q;
  assign alu_en      = alu_en_q;
  assign rf_we       = rf_we_q;
  assign halted      = halted_q;
  assign err         = err_q;
`ifdef ATTOPU_SEQ_PERF_EN
  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_attopu_seq.sv
// Directed + randomized bench for attopu_seq against an instruction-level PC model.
module tb_attopu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, alu_en, rf_we, halt_req, halted, err;
  logic [15:0] imem_addr, imem_rdata, instruction, PC;
  logic [1:0]  rf_raddr1, rf_raddr2, rf_waddr;
`ifdef ATTOPU_SEQ_PERF_EN
  logic [15:0] retired_cnt, w_retired_cnt;
`endif

  // second instance starting at 16'hFFFF to exercise PC wrap
  logic        w_req, w_alu_en, w_rf_we, w_halted, w_err;
  logic [15:0] w_addr, w_instr, w_PC;
  logic [1:0]  w_ra1, w_ra2, w_wa;

  int n_asrt = 0;
  int n_fail = 0;

  logic [15:0] m_pc, m_instr, m_ret;

  always #5 clk = ~clk;

  attopu_seq dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction), .PC(PC),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .alu_en(alu_en), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .halt_req(halt_req), .halted(halted), .err(err)
`ifdef ATTOPU_SEQ_PERF_EN
    ,.retired_cnt(retired_cnt)
`endif
  );

  attopu_seq #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(16'h1000), .instruction(w_instr), .PC(w_PC),
    .rf_raddr1(w_ra1), .rf_raddr2(w_ra2), .alu_en(w_alu_en), .rf_we(w_rf_we),
    .rf_waddr(w_wa), .halt_req(1'b0), .halted(w_halted), .err(w_err)
`ifdef ATTOPU_SEQ_PERF_EN
    ,.retired_cnt(w_retired_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at a negedge in FETCH
  // (or HALT_STOP for a HALT instruction).
  task automatic run_instr(input logic [15:0] ins, input int waits, input bit hreq);
    logic [3:0] op;
    op = ins[15:12];
    for (int w = 0; w < waits; w++) begin
      chk("req_hold", imem_req, 16'd1);
      chk("addr_hold", imem_addr, m_pc);
      chk("instr_stable", instruction, m_instr);
      chk("no_err_wait", err, 16'd0);
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
      @(negedge clk);
    end
    chk("req", imem_req, 16'd1);
    chk("addr", imem_addr, m_pc);
    imem_ack = 1'b1; imem_rdata = ins;
    @(negedge clk);
    m_instr = ins;
    imem_ack = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
    chk("dec_instr", instruction, ins);
    chk("dec_raddr1", rf_raddr1, {14'd0, ins[9:8]});
    chk("dec_raddr2", rf_raddr2, {14'd0, ins[7:6]});
    chk("dec_alu_en", alu_en, 16'd0);
    chk("dec_req", imem_req, 16'd0);
    @(negedge clk);
    imem_ack = 1'($urandom_range(0, 1));
    chk("exe_alu_en", alu_en, 16'd1);
    chk("exe_rf_we", rf_we, 16'd0);
    chk("exe_req", imem_req, 16'd0);
    if (op == 4'hE) begin
      @(negedge clk);
      imem_ack = 1'b0;
      chk("hs_halted", halted, 16'd1);
      chk("hs_rf_we", rf_we, 16'd0);
      chk("hs_pc", PC, m_pc);
      repeat (6) @(negedge clk);
      chk("hs_sticky", halted, 16'd1);
      chk("hs_pc_hold", PC, m_pc);
      chk("hs_req", imem_req, 16'd0);
      return;
    end
    halt_req = hreq;
    @(negedge clk);
    chk("wb_rf_we", rf_we, (op == 4'hF) ? 16'd0 : 16'd1);
    if (op != 4'hF) chk("wb_waddr", rf_waddr, {14'd0, ins[11:10]});
    chk("wb_alu_en", alu_en, 16'd0);
    chk("wb_pc_old", PC, m_pc);
    m_pc  = (op == 4'hF) ? {8'h00, ins[7:0]} : m_pc + 16'd1;
    m_ret = m_ret + 16'd1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("pc_next", PC, m_pc);
    chk("rf_we_pulse", rf_we, 16'd0);
    if (hreq) begin
      chk("hx_halted", halted, 16'd1);
      chk("hx_req", imem_req, 16'd0);
      repeat (2) @(negedge clk);
      chk("hx_hold", halted, 16'd1);
      chk("hx_pc", PC, m_pc);
      halt_req = 1'b0;
      @(negedge clk);
    end
    chk("nx_halted", halted, 16'd0);
    chk("nx_req", imem_req, 16'd1);
    chk("nx_addr", imem_addr, m_pc);
`ifdef ATTOPU_SEQ_PERF_EN
    chk("retired", retired_cnt, m_ret);
`endif
  endtask

  initial begin
    int n;
    logic [15:0] ins;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; halt_req = 1'b0;
    m_pc = 16'h0000; m_instr = 16'h0000; m_ret = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", PC, 16'h0000);
    chk("rst_req", imem_req, 16'd0);
    chk("rst_err", err, 16'd0);
    chk("rst_halted", halted, 16'd0);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_strobes", {alu_en, rf_we}, 16'd0);
    chk("rst_addrs", {rf_raddr1, rf_raddr2, rf_waddr}, 16'd0);
    chk("rst_wpc", w_PC, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", imem_req, 16'd1);
    chk("first_addr", imem_addr, 16'h0000);

    run_instr(16'h1640, 0, 1'b0);
    chk("wrap_pc", w_PC, 16'h0000);
    run_instr({4'($urandom_range(0, 13)), 12'($urandom)}, 3, 1'b0);
    run_instr(16'hF02A, 0, 1'b0);
    run_instr({4'($urandom_range(0, 13)), 12'($urandom)}, 1, 1'b1);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) ins = {4'hF, 12'($urandom)};
      else                           ins = {4'($urandom_range(0, 13)), 12'($urandom)};
      run_instr(ins, int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0));
    end

    // reset in the middle of a waiting fetch
    imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", imem_req, 16'd0);
    chk("rst_mid_pc", PC, 16'h0000);
    @(negedge clk);
    chk("rst_mid_we", rf_we, 16'd0);
    rst = 1'b0;
    m_pc = 16'h0000; m_instr = 16'h0000; m_ret = 16'h0;
    @(negedge clk);
    chk("rel_req", imem_req, 16'd1);

    // fetch timeout
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", 16'(n), 16'd15);
    chk("to_err", err, 16'd1);
    chk("to_halted", halted, 16'd1);
    chk("to_req", imem_req, 16'd0);
    imem_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_sticky", {err, halted, imem_req}, 16'b110);
    imem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("to_rst_err", err, 16'd0);
    rst = 1'b0;
    m_pc = 16'h0000; m_instr = 16'h0000; m_ret = 16'h0;
    @(negedge clk);

    run_instr({4'($urandom_range(0, 13)), 12'($urandom)}, 0, 1'b0);
    run_instr(16'hE000, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
